// File: rtl/grey_pkg.sv
// Shared constants and Gray/binary conversion helpers for the Gray step tracker.
package grey_pkg;

  localparam int GREY_WIDTH       = 5;
  localparam int GREY_SYNC_STAGES = 2;
  localparam int GREY_CNT_W       = 16;

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/grey_to_bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module grey_to_bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/grey_step_tracker.sv
// Synchronises a Gray-coded input, decodes it and classifies each change as +1/-1 step or error.
// Optional build macro GREY_GLITCH_FILTER_EN requires two equal synchronised samples before use.
module grey_step_tracker
  import grey_pkg::*;
#(
  parameter int WIDTH       = GREY_WIDTH,
  parameter int SYNC_STAGES = GREY_SYNC_STAGES,
  parameter int CNT_W       = GREY_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] g_in,
  input  logic             clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             step_valid,
  output logic             dir_up,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] step_cnt
);

  logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] sync_vld_q;
  logic [WIDTH-1:0]       s;
  logic                   s_vld;
  logic [WIDTH-1:0]       samp;
  logic                   samp_ok;
  logic [WIDTH-1:0]       d;

  logic [WIDTH-1:0] cur_q, cur_d;
  logic             primed_q, primed_d;
  logic             step_valid_q, step_valid_d;
  logic             dir_up_q, dir_up_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Stage: input synchroniser; the valid bits mark when the chain holds real samples after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_vld_q <= '0;
    end else begin
      sync_q[0] <= g_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s     = sync_q[SYNC_STAGES-1];
  assign s_vld = sync_vld_q[SYNC_STAGES-1];

`ifdef GREY_GLITCH_FILTER_EN
  logic [WIDTH-1:0] hold_q;
  logic             hold_vld_q;

  // Stage: glitch filter; a sample is used only once it matched on two consecutive cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= s;
      hold_vld_q <= s_vld;
    end
  end

  assign samp    = hold_q;
  assign samp_ok = hold_vld_q & s_vld & (s == hold_q);
`else
  assign samp    = s;
  assign samp_ok = s_vld;
`endif

  grey_to_bin #(.WIDTH(WIDTH)) u_dec (
    .gray_i (samp),
    .bin_o  (d)
  );

  // Stage: compare decoded value with the tracked value and update counters
  always_comb begin
    cur_d        = cur_q;
    primed_d     = primed_q;
    step_valid_d = 1'b0;
    dir_up_d     = dir_up_q;
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;
    step_cnt_d   = step_cnt_q;
    if (clr) begin
      step_cnt_d   = '0;
      err_sticky_d = 1'b0;
      primed_d     = 1'b0;
      if (samp_ok) cur_d = d;
    end else if (samp_ok) begin
      cur_d = d;
      if (!primed_q) begin
        primed_d = 1'b1;
      end else if (d == cur_q) begin
        cur_d = cur_q;
      end else if (d == cur_q + WIDTH'(1)) begin
        step_valid_d = 1'b1;
        dir_up_d     = 1'b1;
        step_cnt_d   = sat_inc(step_cnt_q);
      end else if (d == cur_q - WIDTH'(1)) begin
        step_valid_d = 1'b1;
        dir_up_d     = 1'b0;
        step_cnt_d   = sat_inc(step_cnt_q);
      end else begin
        err_d        = 1'b1;
        err_sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q        <= '0;
      primed_q     <= 1'b0;
      step_valid_q <= 1'b0;
      dir_up_q     <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      step_cnt_q   <= '0;
    end else begin
      cur_q        <= cur_d;
      primed_q     <= primed_d;
      step_valid_q <= step_valid_d;
      dir_up_q     <= dir_up_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  assign bin_out    = cur_q;
  assign step_valid = step_valid_q;
  assign dir_up     = dir_up_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_grey_step_tracker.sv
// Directed bench for grey_step_tracker (WIDTH=5, SYNC_STAGES=2, CNT_W=16).
module tb_grey_step_tracker;

`ifdef GREY_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  g_in;
  logic        clr;
  logic [4:0]  bin_out;
  logic        step_valid;
  logic        dir_up;
  logic        err;
  logic        err_sticky;
  logic [15:0] step_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  grey_step_tracker #(.WIDTH(5), .SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .g_in       (g_in),
    .clr        (clr),
    .bin_out    (bin_out),
    .step_valid (step_valid),
    .dir_up     (dir_up),
    .err        (err),
    .err_sticky (err_sticky),
    .step_cnt   (step_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [4:0] g);
    rst_n = 1'b0;
    clr   = 1'b0;
    g_in  = g;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (LAT) tick();
  endtask

  task automatic step_to(input logic [4:0] g);
    g_in = g;
    repeat (LAT) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    g_in  = 5'b00000;
    tick();
    tick();
    chk("rst_bin", bin_out, 0);
    chk("rst_sv", step_valid, 0);
    chk("rst_dir", dir_up, 0);
    chk("rst_err", err, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_cnt", step_cnt, 0);

    // 1: first sample after release only primes
    g_in  = 5'b00011;
    rst_n = 1'b1;
    repeat (LAT - 1) tick();
    chk("t1_bin_early", bin_out, 0);
    tick();
    chk("t1_bin", bin_out, 2);
    chk("t1_sv", step_valid, 0);
    chk("t1_err", err, 0);
    tick();
    chk("t1_sticky", err_sticky, 0);
    chk("t1_cnt", step_cnt, 0);

    // 2: three up steps
    do_reset(5'b00000);
    chk("t2_bin0", bin_out, 0);
    step_to(5'b00001);
    chk("t2_sv1", step_valid, 1);
    chk("t2_dir1", dir_up, 1);
    chk("t2_cnt1", step_cnt, 1);
    chk("t2_bin1", bin_out, 1);
    tick();
    chk("t2_sv1_off", step_valid, 0);
    step_to(5'b00011);
    chk("t2_sv2", step_valid, 1);
    chk("t2_cnt2", step_cnt, 2);
    chk("t2_bin2", bin_out, 2);
    tick();
    step_to(5'b00010);
    chk("t2_sv3", step_valid, 1);
    chk("t2_cnt3", step_cnt, 3);
    chk("t2_bin3", bin_out, 3);
    chk("t2_dir3", dir_up, 1);
    tick();
    chk("t2_sv3_off", step_valid, 0);

    // 3: wrap 31 -> 0 up, 0 -> 31 down
    do_reset(5'b10000);
    chk("t3_bin31", bin_out, 31);
    chk("t3_cnt0", step_cnt, 0);
    step_to(5'b00000);
    chk("t3_up_sv", step_valid, 1);
    chk("t3_up_dir", dir_up, 1);
    chk("t3_up_bin", bin_out, 0);
    tick();
    step_to(5'b10000);
    chk("t3_dn_sv", step_valid, 1);
    chk("t3_dn_dir", dir_up, 0);
    chk("t3_dn_bin", bin_out, 31);
    chk("t3_dn_cnt", step_cnt, 2);
    tick();
    chk("t3_dir_hold", dir_up, 0);
    chk("t3_sv_off", step_valid, 0);

    // 4: illegal jump 0 -> 2, then clear
    step_to(5'b00000);
    chk("t4_pre_cnt", step_cnt, 3);
    tick();
    step_to(5'b00011);
    chk("t4_err", err, 1);
    chk("t4_sticky", err_sticky, 1);
    chk("t4_sv", step_valid, 0);
    chk("t4_cnt", step_cnt, 3);
    chk("t4_bin", bin_out, 2);
    chk("t4_dir", dir_up, 1);
    tick();
    chk("t4_err_off", err, 0);
    chk("t4_sticky_hold", err_sticky, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_clr_sticky", err_sticky, 0);
    chk("t4_clr_cnt", step_cnt, 0);
    chk("t4_clr_bin", bin_out, 2);
    tick();

    // 5: clr coincides with a detected +1 step
    g_in = 5'b00010;
    repeat (LAT - 1) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_sv", step_valid, 0);
    chk("t5_cnt", step_cnt, 0);
    chk("t5_bin", bin_out, 3);
    tick();
    chk("t5_sv_after", step_valid, 0);
    chk("t5_err_after", err, 0);
    step_to(5'b00110);
    chk("t5_next_sv", step_valid, 1);
    chk("t5_next_cnt", step_cnt, 1);
    chk("t5_next_bin", bin_out, 4);
    tick();

    // mid-operation asynchronous reset
    rst_n = 1'b0;
    #1;
    chk("mr_bin", bin_out, 0);
    chk("mr_dir", dir_up, 0);
    chk("mr_cnt", step_cnt, 0);
    tick();
    rst_n = 1'b1;
    repeat (LAT) tick();
    chk("mr_prime_bin", bin_out, 4);
    chk("mr_prime_sv", step_valid, 0);
    chk("mr_prime_err", err, 0);

    // 6: single-cycle glitch on the input
`ifdef GREY_GLITCH_FILTER_EN
    g_in = 5'b00111;
    tick();
    g_in = 5'b00110;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_glitch_sv", step_valid, 0);
      chk("t6_glitch_err", err, 0);
    end
    chk("t6_glitch_bin", bin_out, 4);
    step_to(5'b00111);
    chk("t6_hold_sv", step_valid, 1);
    chk("t6_hold_bin", bin_out, 5);
    chk("t6_hold_cnt", step_cnt, 1);
`else
    g_in = 5'b00111;
    tick();
    g_in = 5'b00110;
    repeat (LAT - 1) tick();
    chk("t6_up_sv", step_valid, 1);
    chk("t6_up_dir", dir_up, 1);
    chk("t6_up_bin", bin_out, 5);
    tick();
    chk("t6_dn_sv", step_valid, 1);
    chk("t6_dn_dir", dir_up, 0);
    chk("t6_dn_bin", bin_out, 4);
    chk("t6_dn_cnt", step_cnt, 2);
    tick();
    chk("t6_sv_off", step_valid, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
